counter_sequencer: RTL and testbench

//  Programmable controller that sequences a WIDTH-bit synchronous up counter:

---
 rtl/counter_sequencer.sv | 160 ++++++++++++++++
 tb/tb_counter_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sequencer.sv
// counter_sequencer: start/stop/pause controller that owns a WIDTH-bit up
// counter. Counts in prescaled steps and ends each period either in a
// one-shot DONE state or by reloading to zero.
// All state moves on the falling clock edge so that it lines up with the
// counter datapath this block feeds. Reset is synchronous and active-high.
module counter_sequencer #(
    parameter int WIDTH      = 4,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  pause,
    input  logic                  mode,
    input  logic [WIDTH-1:0]      period,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [WIDTH-1:0]      q,
    output logic                  busy,
    output logic                  done,
    output logic                  tc,
    output logic                  err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0]      Q_ONE = WIDTH'(1);
    localparam logic [PRESCALE_W-1:0] P_ONE = PRESCALE_W'(1);

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      count_q, count_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [WIDTH-1:0]      period_s_q, period_s_d;
    logic [PRESCALE_W-1:0] prescale_s_q, prescale_s_d;
    logic                  mode_s_q, mode_s_d;
    logic                  tc_q, tc_d;
    logic                  err_q, err_d;

    logic                  counting;
    logic                  step;
    logic                  at_terminal;
    logic                  period_ok;

    // Register every piece of state on the falling edge; reset wins over all.
    always_ff @(negedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            presc_q      <= '0;
            period_s_q   <= '0;
            prescale_s_q <= '0;
            mode_s_q     <= 1'b0;
            tc_q         <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            presc_q      <= presc_d;
            period_s_q   <= period_s_d;
            prescale_s_q <= prescale_s_d;
            mode_s_q     <= mode_s_d;
            tc_q         <= tc_d;
            err_q        <= err_d;
        end
    end

    // Step qualification: the counter advances when running with pause low
    // (a paused run resuming counts on the same edge pause is seen low) and
    // the prescaler has reached the latched compare value.
    always_comb begin
        period_ok   = (period != '0);
        counting    = ((state_q == S_RUN) || (state_q == S_PAUSE)) && !pause;
        step        = counting && (presc_q == prescale_s_q);
        at_terminal = (count_q == period_s_q);
    end

    // Next-state and next-datapath decode; priority is stop, then start,
    // then pause/count. A start while running is flagged but does not
    // disturb the run in progress.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        presc_d      = presc_q;
        period_s_d   = period_s_q;
        prescale_s_d = prescale_s_q;
        mode_s_d     = mode_s_q;
        tc_d         = 1'b0;
        err_d        = 1'b0;

        if (stop) begin
            state_d = S_IDLE;
            count_d = '0;
            presc_d = '0;
        end else if (start && ((state_q == S_IDLE) || (state_q == S_DONE))) begin
            if (period_ok) begin
                state_d      = S_RUN;
                count_d      = '0;
                presc_d      = '0;
                period_s_d   = period;
                prescale_s_d = prescale;
                mode_s_d     = mode;
            end else begin
                err_d = 1'b1;
            end
        end else begin
            if (start) begin
                err_d = 1'b1;
            end

            case (state_q)
                S_RUN: begin
                    if (pause) begin
                        state_d = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (!pause) begin
                        state_d = S_RUN;
                    end
                end
                default: begin
                end
            endcase

            if (counting) begin
                if (step) begin
                    presc_d = '0;
                    if (at_terminal) begin
                        tc_d = 1'b1;
                        if (mode_s_q) begin
                            count_d = '0;
                        end else begin
                            state_d = S_DONE;
                            count_d = period_s_q;
                        end
                    end else begin
                        count_d = count_q + Q_ONE;
                    end
                end else begin
                    presc_d = presc_q + P_ONE;
                end
            end
        end
    end

    // Status outputs follow the state register directly; pulses are registered.
    always_comb begin
        q    = count_q;
        busy = (state_q == S_RUN) || (state_q == S_PAUSE);
        done = (state_q == S_DONE);
        tc   = tc_q;
        err  = err_q;
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer. The DUT moves on the falling edge;
// inputs are driven and outputs checked 2 time units after each falling edge.
module tb_counter_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic       pause;
    logic       mode;
    logic [3:0] period;
    logic [3:0] prescale;
    logic [3:0] q;
    logic       busy;
    logic       done;
    logic       tc;
    logic       err;

    int checkCount;
    int passCount;
    int failCount;

    counter_sequencer #(
        .WIDTH      (4),
        .PRESCALE_W (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .pause    (pause),
        .mode     (mode),
        .period   (period),
        .prescale (prescale),
        .q        (q),
        .busy     (busy),
        .done     (done),
        .tc       (tc),
        .err      (err)
    );

    // Free-running clock, falling edges at 10, 20, 30, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance past one active (falling) edge and settle.
    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    // Set the programming inputs for the next start.
    task automatic applyStimulus(input logic [3:0] per, input logic [3:0] pre,
                                 input logic md);
        period   = per;
        prescale = pre;
        mode     = md;
    endtask

    // Compare all outputs against the hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [3:0] expQ,
                               input logic expBusy, input logic expDone,
                               input logic expTc, input logic expErr);
        logic [7:0] obs;
        logic [7:0] expv;
        obs  = {q, busy, done, tc, err};
        expv = {expQ, expBusy, expDone, expTc, expErr};
        checkCount++;
        assert (obs === expv) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed q=%0d busy=%b done=%b tc=%b err=%b, expected q=%0d busy=%b done=%b tc=%b err=%b",
                   tag, q, busy, done, tc, err, expQ, expBusy, expDone, expTc, expErr);
        end
    endtask

    initial begin
        logic [3:0] arQ  [12];
        logic       arTc [12];
        checkCount = 0;
        passCount  = 0;
        failCount  = 0;

        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        pause = 1'b0;
        applyStimulus(4'd0, 4'd0, 1'b0);

        // Reset state
        tick();
        checkOutput("reset", 4'd0, 0, 0, 0, 0);
        rst = 1'b0;
        tick();
        checkOutput("idle", 4'd0, 0, 0, 0, 0);

        // Start with period zero is rejected
        start = 1'b1;
        tick();
        checkOutput("reject_p0", 4'd0, 0, 0, 0, 1);
        start = 1'b0;
        tick();
        checkOutput("reject_p0_clear", 4'd0, 0, 0, 0, 0);

        // One-shot, period 3, prescale 0
        applyStimulus(4'd3, 4'd0, 1'b0);
        start = 1'b1;
        tick();
        checkOutput("os_q0", 4'd0, 1, 0, 0, 0);
        start = 1'b0;
        applyStimulus(4'd9, 4'd5, 1'b1);
        tick();
        checkOutput("os_q1", 4'd1, 1, 0, 0, 0);
        tick();
        checkOutput("os_q2", 4'd2, 1, 0, 0, 0);
        tick();
        checkOutput("os_q3", 4'd3, 1, 0, 0, 0);
        tick();
        checkOutput("os_done_tc", 4'd3, 0, 1, 1, 0);
        tick();
        checkOutput("os_done_hold", 4'd3, 0, 1, 0, 0);

        // Start with period zero from DONE is rejected, DONE held
        applyStimulus(4'd0, 4'd0, 1'b0);
        start = 1'b1;
        tick();
        checkOutput("done_reject", 4'd3, 0, 1, 0, 1);
        start = 1'b0;

        // Auto-reload, period 2, prescale 1, restarted from DONE
        applyStimulus(4'd2, 4'd1, 1'b1);
        start = 1'b1;
        tick();
        checkOutput("ar_start", 4'd0, 1, 0, 0, 0);
        start = 1'b0;
        applyStimulus(4'd7, 4'd0, 1'b0);
        arQ  = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd0,
                 4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd0};
        arTc = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 12; i++) begin
            tick();
            checkOutput($sformatf("ar_seq%0d", i), arQ[i], 1, 0, arTc[i], 0);
        end

        // Start during RUN: err pulse, sequence continues
        start = 1'b1;
        tick();
        checkOutput("run_reject", 4'd0, 1, 0, 0, 1);
        start = 1'b0;
        tick();
        checkOutput("run_reject_cont", 4'd1, 1, 0, 0, 0);

        // Stop aborts to IDLE
        stop = 1'b1;
        tick();
        checkOutput("stop", 4'd0, 0, 0, 0, 0);
        stop = 1'b0;

        // Pause at q=2 for three edges
        applyStimulus(4'd9, 4'd0, 1'b0);
        start = 1'b1;
        tick();
        checkOutput("p_q0", 4'd0, 1, 0, 0, 0);
        start = 1'b0;
        tick();
        tick();
        checkOutput("p_q2", 4'd2, 1, 0, 0, 0);
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("p_hold%0d", i), 4'd2, 1, 0, 0, 0);
        end
        pause = 1'b0;
        tick();
        checkOutput("p_resume", 4'd3, 1, 0, 0, 0);
        tick();
        tick();
        checkOutput("p_q5", 4'd5, 1, 0, 0, 0);

        // Stop and start on the same edge: stop wins, no err
        stop  = 1'b1;
        start = 1'b1;
        tick();
        checkOutput("collision", 4'd0, 0, 0, 0, 0);
        stop  = 1'b0;
        start = 1'b0;
        tick();
        checkOutput("collision_after", 4'd0, 0, 0, 0, 0);

        // Reset mid-run at q=5, prescaler=2
        applyStimulus(4'd9, 4'd2, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 17; i++) begin
            tick();
        end
        checkOutput("rr_q5", 4'd5, 1, 0, 0, 0);
        rst = 1'b1;
        tick();
        checkOutput("rr_reset", 4'd0, 0, 0, 0, 0);
        rst = 1'b0;
        tick();
        checkOutput("rr_idle", 4'd0, 0, 0, 0, 0);
        applyStimulus(4'd2, 4'd0, 1'b0);
        start = 1'b1;
        tick();
        checkOutput("rr_restart", 4'd0, 1, 0, 0, 0);
        start = 1'b0;
        tick();
        checkOutput("rr_q1", 4'd1, 1, 0, 0, 0);
        tick();
        tick();
        checkOutput("rr_done", 4'd2, 0, 1, 1, 0);

        // Full-range auto-reload, period 15
        applyStimulus(4'd15, 4'd0, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 16; i++) begin
            tick();
            checkOutput($sformatf("fr_q%0d", i), 4'(i), 1, 0, 0, 0);
        end
        tick();
        checkOutput("fr_wrap", 4'd0, 1, 0, 1, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
